// File: rtl/dft64_framer.sv
// rtl/dft64_framer.sv - ping-pong 64-sample framer that bursts 8-lane beats to dft64 and waits for done
// Optional watchdog on WAIT_DONE: define DFT64_FRAMER_TIMEOUT_EN.
module dft64_framer #(
  parameter int SAMPLE_W    = 16,
  parameter int LANES       = 8,
  parameter int BEATS       = 8,
  parameter int TIMEOUT_CYC = 6
) (
  input  logic                        clk,
  input  logic                        areset_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [SAMPLE_W-1:0]         in_sample,
  output logic [LANES*SAMPLE_W-1:0]   samples,
  output logic                        rel,
  input  logic                        done,
  output logic                        busy,
  output logic [15:0]                 frames_sent,
  output logic                        timeout_err
);

  localparam int FRAME  = LANES * BEATS;
  localparam int IDX_W  = $clog2(FRAME);
  localparam int BEAT_W = $clog2(BEATS);
  localparam int LANE_W = $clog2(LANES);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    BURST     = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [SAMPLE_W-1:0]       mem [2*FRAME];
  logic [1:0]                full, full_nxt;
  logic                      wr_bank, rd_bank;
  logic [IDX_W-1:0]          wr_idx;
  logic [BEAT_W-1:0]         beat_cnt;
  logic                      accept, wr_last, release_now, timeout_hit;
  logic                      load_beat;
  logic [LANES*SAMPLE_W-1:0] beat_data;

  // Write side
  assign in_ready = !full[wr_bank];
  assign accept   = in_valid && in_ready;
  assign wr_last  = (wr_idx == IDX_W'(FRAME - 1));

  always_ff @(posedge clk) begin
    if (accept) begin
      mem[{wr_bank, wr_idx}] <= in_sample;
    end
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      wr_bank <= 1'b0;
      wr_idx  <= '0;
    end else if (accept) begin
      if (wr_last) begin
        wr_idx  <= '0;
        wr_bank <= ~wr_bank;
      end else begin
        wr_idx  <= wr_idx + 1'b1;
      end
    end
  end

  // Set and clear never hit the same bank: a write needs its bank empty, a release needs it full.
  always_comb begin
    full_nxt = full;
    if (accept && wr_last) full_nxt[wr_bank] = 1'b1;
    if (release_now)       full_nxt[rd_bank] = 1'b0;
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) full <= 2'b00;
    else           full <= full_nxt;
  end

  // Lane 0 lands in the MSBs of the beat
  always_comb begin
    beat_data = '0;
    for (int l = 0; l < LANES; l++) begin
      beat_data[(LANES-1-l)*SAMPLE_W +: SAMPLE_W] = mem[{rd_bank, beat_cnt, LANE_W'(l)}];
    end
  end

  // Watchdog
`ifdef DFT64_FRAMER_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT_CYC + 1);
  logic [WAIT_W-1:0] wait_cnt;

  assign timeout_hit = (state == WAIT_DONE) && !done && (wait_cnt == WAIT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state == WAIT_DONE) wait_cnt <= wait_cnt + 1'b1;
      else                    wait_cnt <= '0;
      if (timeout_hit) timeout_err <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = (TIMEOUT_CYC < 0);
`endif

  assign release_now = (state == WAIT_DONE) && (done || timeout_hit);

  // Read FSM: state register
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) state <= IDLE;
    else           state <= state_nxt;
  end

  // Read FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (full[rd_bank]) state_nxt = BURST;
      BURST:     if (beat_cnt == BEAT_W'(BEATS - 1)) state_nxt = WAIT_DONE;
      WAIT_DONE: if (release_now) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Read FSM: outputs
  always_comb begin
    busy      = (state != IDLE);
    load_beat = (state == BURST);
  end

  // Beat registers, bank pointer and release bookkeeping
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      rel         <= 1'b0;
      samples     <= '0;
      beat_cnt    <= '0;
      rd_bank     <= 1'b0;
      frames_sent <= 16'd0;
    end else begin
      rel <= load_beat;
      if (load_beat) begin
        samples  <= beat_data;
        beat_cnt <= beat_cnt + 1'b1;
      end else if (state == IDLE) begin
        beat_cnt <= '0;
      end
      if (release_now) begin
        rd_bank     <= ~rd_bank;
        frames_sent <= frames_sent + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_dft64_framer.sv
// tb/tb_dft64_framer.sv - scoreboard bench for dft64_framer: directed frames, done timing, reset abort
module tb_dft64_framer;
  localparam int SW    = 16;
  localparam int LANES = 8;
  localparam int BEATS = 8;
  localparam int FRAME = 64;

  logic                  clk = 1'b0;
  logic                  areset_n = 1'b0;
  logic                  in_valid = 1'b0;
  logic                  done = 1'b0;
  logic [SW-1:0]         in_sample = '0;
  logic                  in_ready, rel, busy, timeout_err;
  logic [LANES*SW-1:0]   samples;
  logic [15:0]           frames_sent;

  int total = 0;
  int bad   = 0;
  int rel_run = 0;
  logic [LANES*SW-1:0] exp_q[$];
  logic [LANES*SW-1:0] cap[BEATS];
  logic [SW-1:0]       fr[FRAME];

  dft64_framer dut (
    .clk(clk), .areset_n(areset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_sample(in_sample), .samples(samples), .rel(rel), .done(done),
    .busy(busy), .frames_sent(frames_sent), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Monitor: every rel beat is popped against the scoreboard; burst length checked on rel fall
  always @(negedge clk) begin
    if (!areset_n) begin
      rel_run = 0;
    end else if (rel) begin
      if (rel_run < BEATS) cap[rel_run] = samples;
      rel_run++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL beat_extra: got beat %0h required no beat", samples);
      end else begin
        check("beat_data", samples, exp_q.pop_front());
      end
    end else if (rel_run != 0) begin
      check("rel_len", rel_run, 8);
      rel_run = 0;
    end
  end

  function automatic logic [LANES*SW-1:0] pack(input int k);
    logic [LANES*SW-1:0] b = '0;
    for (int l = 0; l < LANES; l++) b[(LANES-1-l)*SW +: SW] = fr[k*LANES + l];
    return b;
  endfunction

  task automatic send(input logic [SW-1:0] v);
    int n = 0;
    in_valid  = 1'b1;
    in_sample = v;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL send_stall: in_ready got 0 required 1");
    end
    @(negedge clk);
  endtask

  task automatic send_frame();
    for (int k = 0; k < BEATS; k++) exp_q.push_back(pack(k));
    for (int n = 0; n < FRAME; n++) send(fr[n]);
    in_valid = 1'b0;
  endtask

  task automatic wait_rel(input logic lvl, input string name);
    int n = 0;
    while (rel !== lvl && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (rel !== lvl) begin
      total++;
      bad++;
      $display("FAIL %s: rel got %0b required %0b", name, rel, lvl);
    end
  endtask

  task automatic pulse_done(input int len);
    done = 1'b1;
    repeat (len) @(negedge clk);
    done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_rel", rel, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_frames", frames_sent, 0);
    check("rst_samples", samples, 0);
    check("rst_timeout", timeout_err, 0);
    areset_n = 1'b1;
    @(negedge clk);

    // Ramp frame: latency, beat contents, one release
    for (int n = 0; n < FRAME; n++) fr[n] = SW'(n);
    send_frame();
    check("lat_e0", rel, 0);
    @(negedge clk);
    check("lat_e1", rel, 0);
    @(negedge clk);
    check("lat_e2", rel, 1);
    wait_rel(1'b0, "t1_end");
    check("ramp_beat0", cap[0], 128'h0000_0001_0002_0003_0004_0005_0006_0007);
    check("ramp_beat7", cap[7], 128'h0038_0039_003A_003B_003C_003D_003E_003F);
    repeat (2) @(negedge clk);
    check("t1_busy_wait", busy, 1);
    pulse_done(1);
    check("t1_frames", frames_sent, 1);
    check("t1_idle", busy, 0);

    // Sine 1 kHz @ 48 kHz, amplitude 256
    for (int n = 0; n < FRAME; n++) fr[n] = SW'(int'(256.0 * $sin(2.0 * 3.14159265358979 * n / 48.0)));
    send_frame();
    wait_rel(1'b1, "t2_start");
    wait_rel(1'b0, "t2_end");
    check("sine_b1_l4", cap[1][(LANES-1-4)*SW +: SW], 16'h0100);
    check("sine_b0_l0", cap[0][(LANES-1)*SW +: SW], 16'h0000);
    @(negedge clk);
    pulse_done(1);
    check("t2_frames", frames_sent, 2);

    // Two frames back-to-back, done withheld: ping-pong stall and release
    for (int n = 0; n < FRAME; n++) fr[n] = SW'(16'h1000 + n);
    send_frame();
    for (int n = 0; n < FRAME; n++) fr[n] = SW'(16'h2000 + n);
    send_frame();
    check("t3_in_ready_low", in_ready, 0);
    check("t3_busy", busy, 1);
    repeat (20) @(negedge clk);
    check("t3_still_low", in_ready, 0);
    done = 1'b1;
    @(negedge clk);
    check("t3_in_ready_up", in_ready, 1);
    check("t3_rel_d0", rel, 0);
    @(negedge clk);
    done = 1'b0;
    check("t3_rel_d1", rel, 0);
    check("t3_frames_a", frames_sent, 3);
    @(negedge clk);
    check("t3_rel_d2", rel, 1);
    wait_rel(1'b0, "t3_end");
    repeat (3) @(negedge clk);
    check("t3_held_done_once", frames_sent, 3);
    check("t3_wait_b", busy, 1);
    pulse_done(1);
    check("t3_frames_b", frames_sent, 4);
    check("t3_idle", busy, 0);

    // done only during BURST is ignored
    for (int n = 0; n < FRAME; n++) fr[n] = SW'(16'h3000 + 3 * n);
    send_frame();
    wait_rel(1'b1, "t6_start");
    pulse_done(2);
    wait_rel(1'b0, "t6_end");
    repeat (4) @(negedge clk);
    check("t6_still_wait", busy, 1);
    check("t6_frames_hold", frames_sent, 4);
    pulse_done(1);
    check("t6_frames", frames_sent, 5);

    // Reset during beat 4 aborts the burst at once
    for (int n = 0; n < FRAME; n++) fr[n] = SW'(16'h4000 - n);
    send_frame();
    wait_rel(1'b1, "t4_start");
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 areset_n = 1'b0;
    #1;
    check("t4_rel", rel, 0);
    check("t4_busy", busy, 0);
    check("t4_in_ready", in_ready, 1);
    check("t4_frames", frames_sent, 0);
    exp_q.delete();
    @(negedge clk);
    #2 areset_n = 1'b1;
    @(negedge clk);
    for (int n = 0; n < FRAME; n++) fr[n] = SW'(16'h5000 + n);
    send_frame();
    wait_rel(1'b1, "t4b_start");
    wait_rel(1'b0, "t4b_end");
    check("t4b_first_beat", cap[0], 128'h5000_5001_5002_5003_5004_5005_5006_5007);
    pulse_done(1);
    check("t4b_frames", frames_sent, 1);

`ifdef DFT64_FRAMER_TIMEOUT_EN
    for (int n = 0; n < FRAME; n++) fr[n] = SW'(16'h6000 + n);
    send_frame();
    wait_rel(1'b1, "t5_start");
    wait_rel(1'b0, "t5_end");
    repeat (12) @(negedge clk);
    check("t5_timeout", timeout_err, 1);
    check("t5_frames", frames_sent, 2);
    check("t5_idle", busy, 0);
    for (int n = 0; n < FRAME; n++) fr[n] = SW'(16'h7000 + n);
    send_frame();
    wait_rel(1'b1, "t5b_start");
    wait_rel(1'b0, "t5b_end");
    pulse_done(1);
    check("t5b_frames", frames_sent, 3);
    check("t5b_sticky", timeout_err, 1);
`else
    check("no_timeout", timeout_err, 0);
`endif

    repeat (2) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
